// File: rtl/expr_stream_checker_pkg.sv
// Shared encodings for the streaming expression checker: FSM states, error causes, ASCII constants.
package expr_stream_checker_pkg;

    typedef enum logic [1:0] {
        ST_OPND  = 2'd0,
        ST_NUM   = 2'd1,
        ST_CLOSE = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        EC_NONE     = 3'd0,
        EC_BADCHAR  = 3'd1,
        EC_DIGOVF   = 3'd2,
        EC_DEPTHOVF = 3'd3,
        EC_UNBAL    = 3'd4,
        EC_LEADZ    = 3'd5
    } err_code_t;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_SLASH = 8'h2F;
    localparam logic [7:0] CH_LPAR  = 8'h28;
    localparam logic [7:0] CH_RPAR  = 8'h29;

endpackage

// File: rtl/expr_char_class.sv
// Classifies one ASCII character into digit / operator / paren classes.
// Latency: purely combinational.
// Backpressure: none; classification is independent of flow control.
module expr_char_class
    import expr_stream_checker_pkg::*;
#(
    parameter int OPS_EXT = 0
) (
    input  logic [7:0] in,
    output logic       is_digit,
    output logic       is_op,
    output logic       is_lpar,
    output logic       is_rpar,
    output logic       is_zero
);

    logic w_ext_op;

    assign w_ext_op = (OPS_EXT != 0) && ((in == CH_MINUS) || (in == CH_SLASH));

    assign is_digit = (in >= CH_0) && (in <= CH_9);
    assign is_op    = (in == CH_PLUS) || (in == CH_STAR) || w_ext_op;
    assign is_lpar  = (in == CH_LPAR);
    assign is_rpar  = (in == CH_RPAR);
    assign is_zero  = (in == CH_0);

endmodule

// File: rtl/expr_stream_checker.sv
// Validates an ASCII arithmetic expression stream, one character per in_valid cycle.
// Latency: out/err reflect a character one cycle after it is accepted.
// Backpressure: none; in_valid=0 simply holds all state.
module expr_stream_checker
    import expr_stream_checker_pkg::*;
#(
    parameter int MAX_DIGITS = 4,
    parameter int MAX_DEPTH  = 7,
    parameter int OPS_EXT    = 0,
    parameter int ALLOW_LZ   = 1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [7:0] in,
    input  logic       in_valid,
    output logic       out,
    output logic       err,
    output logic [2:0] err_code,
    output logic [3:0] depth,
    output logic [3:0] digit_cnt
);

    localparam logic [3:0] LP_MAX_DIGITS = 4'(MAX_DIGITS);
    localparam logic [3:0] LP_MAX_DEPTH  = 4'(MAX_DEPTH);

    state_t    r_state, w_cur_state, w_nxt_state;
    err_code_t r_err_code, w_cur_code, w_nxt_code, w_cause;
    logic [3:0] r_depth, w_cur_depth, w_nxt_depth;
    logic [3:0] r_digit_cnt, w_cur_cnt, w_nxt_cnt;
    logic       r_lead_zero, w_cur_lz, w_nxt_lz;
    logic       w_go_err;
    logic       w_is_digit, w_is_op, w_is_lpar, w_is_rpar, w_is_zero;

    expr_char_class #(.OPS_EXT(OPS_EXT)) u_class (
        .in       (in),
        .is_digit (w_is_digit),
        .is_op    (w_is_op),
        .is_lpar  (w_is_lpar),
        .is_rpar  (w_is_rpar),
        .is_zero  (w_is_zero)
    );

    // start folds into the evaluation so a same-cycle character opens a fresh expression
    always_comb begin
        w_cur_state = start ? ST_OPND : r_state;
        w_cur_code  = start ? EC_NONE : r_err_code;
        w_cur_depth = start ? 4'd0    : r_depth;
        w_cur_cnt   = start ? 4'd0    : r_digit_cnt;
        w_cur_lz    = start ? 1'b0    : r_lead_zero;

        w_nxt_state = w_cur_state;
        w_nxt_code  = w_cur_code;
        w_nxt_depth = w_cur_depth;
        w_nxt_cnt   = w_cur_cnt;
        w_nxt_lz    = w_cur_lz;
        w_go_err    = 1'b0;
        w_cause     = EC_BADCHAR;

        if (in_valid) begin
            case (w_cur_state)
                ST_OPND: begin
                    if (w_is_digit) begin
                        w_nxt_state = ST_NUM;
                        w_nxt_cnt   = 4'd1;
                        w_nxt_lz    = w_is_zero;
                    end else if (w_is_lpar) begin
                        if (w_cur_depth < LP_MAX_DEPTH) begin
                            w_nxt_depth = w_cur_depth + 4'd1;
                        end else begin
                            w_go_err = 1'b1;
                            w_cause  = EC_DEPTHOVF;
                        end
                    end else begin
                        w_go_err = 1'b1;
                    end
                end
                ST_NUM, ST_CLOSE: begin
                    if (w_is_digit && (w_cur_state == ST_NUM)) begin
                        if ((ALLOW_LZ == 0) && (w_cur_cnt == 4'd1) && w_cur_lz) begin
                            w_go_err = 1'b1;
                            w_cause  = EC_LEADZ;
                        end else if (w_cur_cnt < LP_MAX_DIGITS) begin
                            w_nxt_cnt = w_cur_cnt + 4'd1;
                        end else begin
                            w_go_err = 1'b1;
                            w_cause  = EC_DIGOVF;
                        end
                    end else if (w_is_op) begin
                        w_nxt_state = ST_OPND;
                        w_nxt_cnt   = 4'd0;
                        w_nxt_lz    = 1'b0;
                    end else if (w_is_rpar) begin
                        if (w_cur_depth != 4'd0) begin
                            w_nxt_state = ST_CLOSE;
                            w_nxt_depth = w_cur_depth - 4'd1;
                            w_nxt_cnt   = 4'd0;
                            w_nxt_lz    = 1'b0;
                        end else begin
                            w_go_err = 1'b1;
                            w_cause  = EC_UNBAL;
                        end
                    end else begin
                        w_go_err = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (w_go_err) begin
            w_nxt_state = ST_ERR;
            w_nxt_code  = w_cause;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= ST_OPND;
            r_err_code  <= EC_NONE;
            r_depth     <= 4'd0;
            r_digit_cnt <= 4'd0;
            r_lead_zero <= 1'b0;
        end else if (in_valid || start) begin
            r_state     <= w_nxt_state;
            r_err_code  <= w_nxt_code;
            r_depth     <= w_nxt_depth;
            r_digit_cnt <= w_nxt_cnt;
            r_lead_zero <= w_nxt_lz;
        end
    end

    assign out       = ((r_state == ST_NUM) || (r_state == ST_CLOSE)) && (r_depth == 4'd0);
    assign err       = (r_state == ST_ERR);
    assign err_code  = r_err_code;
    assign depth     = r_depth;
    assign digit_cnt = r_digit_cnt;

endmodule

// File: tb/tb_expr_stream_checker.sv
// Bench for expr_stream_checker: a default instance and a strict instance (ALLOW_LZ=0, OPS_EXT=1, MAX_DEPTH=2).
module tb_expr_stream_checker;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic [7:0] in;
    logic       in_valid;

    logic       out_a, err_a, out_b, err_b;
    logic [2:0] code_a, code_b;
    logic [3:0] depth_a, depth_b, dcnt_a, dcnt_b;
    logic [12:0] obs_a, obs_b;

    int tests = 0;
    int fails = 0;

    logic [12:0] q_a[$];
    logic [12:0] q_b[$];

    always #5 clk = ~clk;

    expr_stream_checker dut_a (
        .clk(clk), .clr(clr), .start(start), .in(in), .in_valid(in_valid),
        .out(out_a), .err(err_a), .err_code(code_a), .depth(depth_a), .digit_cnt(dcnt_a)
    );

    expr_stream_checker #(.MAX_DIGITS(4), .MAX_DEPTH(2), .OPS_EXT(1), .ALLOW_LZ(0)) dut_b (
        .clk(clk), .clr(clr), .start(start), .in(in), .in_valid(in_valid),
        .out(out_b), .err(err_b), .err_code(code_b), .depth(depth_b), .digit_cnt(dcnt_b)
    );

    assign obs_a = {out_a, err_a, code_a, depth_a, dcnt_a};
    assign obs_b = {out_b, err_b, code_b, depth_b, dcnt_b};

    // {out, err, err_code, depth, digit_cnt}
    function automatic logic [12:0] pk(input logic o, input logic e, input logic [2:0] c,
                                       input logic [3:0] d, input logic [3:0] n);
        return {o, e, c, d, n};
    endfunction

    task automatic step(input logic [7:0] ch, input logic v, input logic s);
        in       = ch;
        in_valid = v;
        start    = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic restart();
        step(8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        clr = 1'b1; start = 1'b0; in = 8'h00; in_valid = 1'b0;
        #12;
        tests++;
        if (obs_a !== 13'd0 || obs_b !== 13'd0) begin
            fails++;
            $display("FAIL reset_hold got a=%h b=%h exp=0", obs_a, obs_b);
        end
        clr = 1'b0;
        step(8'h00, 1'b0, 1'b0);
        tests++;
        if (obs_a !== 13'd0 || obs_b !== 13'd0) begin
            fails++;
            $display("FAIL reset_release got a=%h b=%h exp=0", obs_a, obs_b);
        end
    endtask

    task automatic test_basic();
        string s = "12+(3*45)";
        logic [12:0] e [9];
        logic [12:0] x;
        e = '{pk(1,0,0,0,1), pk(1,0,0,0,2), pk(0,0,0,0,0), pk(0,0,0,1,0), pk(0,0,0,1,1),
              pk(0,0,0,1,0), pk(0,0,0,1,1), pk(0,0,0,1,2), pk(1,0,0,0,0)};
        restart();
        for (int i = 0; i < s.len(); i++) begin
            q_a.push_back(e[i]);
            step(s[i], 1'b1, 1'b0);
            x = q_a.pop_front();
            tests++;
            if (obs_a !== x) begin
                fails++;
                $display("FAIL basic[%0d] got=%h exp=%h", i, obs_a, x);
            end
        end
    endtask

    task automatic test_digovf();
        string s = "12345";
        logic [12:0] e [5];
        logic [12:0] x;
        e = '{pk(1,0,0,0,1), pk(1,0,0,0,2), pk(1,0,0,0,3), pk(1,0,0,0,4), pk(0,1,2,0,4)};
        restart();
        for (int i = 0; i < s.len(); i++) begin
            q_a.push_back(e[i]);
            step(s[i], 1'b1, 1'b0);
            x = q_a.pop_front();
            tests++;
            if (obs_a !== x) begin
                fails++;
                $display("FAIL digovf[%0d] got=%h exp=%h", i, obs_a, x);
            end
        end
    endtask

    task automatic test_parens();
        string s = "((1)))";
        logic [12:0] e [6];
        logic [12:0] x;
        e = '{pk(0,0,0,1,0), pk(0,0,0,2,0), pk(0,0,0,2,1), pk(0,0,0,1,0),
              pk(1,0,0,0,0), pk(0,1,4,0,0)};
        restart();
        for (int i = 0; i < s.len(); i++) begin
            q_a.push_back(e[i]);
            step(s[i], 1'b1, 1'b0);
            x = q_a.pop_front();
            tests++;
            if (obs_a !== x) begin
                fails++;
                $display("FAIL parens[%0d] got=%h exp=%h", i, obs_a, x);
            end
        end
    endtask

    task automatic test_depth_limit();
        string s = "((()";
        logic [12:0] ea [4];
        logic [12:0] eb [4];
        logic [12:0] xa, xb;
        ea = '{pk(0,0,0,1,0), pk(0,0,0,2,0), pk(0,0,0,3,0), pk(0,1,1,3,0)};
        eb = '{pk(0,0,0,1,0), pk(0,0,0,2,0), pk(0,1,3,2,0), pk(0,1,3,2,0)};
        restart();
        for (int i = 0; i < s.len(); i++) begin
            q_a.push_back(ea[i]);
            q_b.push_back(eb[i]);
            step(s[i], 1'b1, 1'b0);
            xa = q_a.pop_front();
            xb = q_b.pop_front();
            tests++;
            if (obs_a !== xa || obs_b !== xb) begin
                fails++;
                $display("FAIL depth[%0d] got a=%h b=%h exp a=%h b=%h", i, obs_a, obs_b, xa, xb);
            end
        end
    endtask

    task automatic test_leading_zero();
        string s = "07";
        logic [12:0] ea [2];
        logic [12:0] eb [2];
        logic [12:0] xa, xb;
        ea = '{pk(1,0,0,0,1), pk(1,0,0,0,2)};
        eb = '{pk(1,0,0,0,1), pk(0,1,5,0,1)};
        restart();
        for (int i = 0; i < s.len(); i++) begin
            q_a.push_back(ea[i]);
            q_b.push_back(eb[i]);
            step(s[i], 1'b1, 1'b0);
            xa = q_a.pop_front();
            xb = q_b.pop_front();
            tests++;
            if (obs_a !== xa || obs_b !== xb) begin
                fails++;
                $display("FAIL leadz[%0d] got a=%h b=%h exp a=%h b=%h", i, obs_a, obs_b, xa, xb);
            end
        end
    endtask

    task automatic test_ops_and_start();
        string s = "3-45";
        logic [12:0] ea [4];
        logic [12:0] eb [4];
        logic [12:0] xa, xb;
        ea = '{pk(1,0,0,0,1), pk(0,1,1,0,1), pk(0,1,1,0,1), pk(1,0,0,0,1)};
        eb = '{pk(1,0,0,0,1), pk(0,0,0,0,0), pk(1,0,0,0,1), pk(1,0,0,0,1)};
        restart();
        for (int i = 0; i < s.len(); i++) begin
            q_a.push_back(ea[i]);
            q_b.push_back(eb[i]);
            step(s[i], 1'b1, (i == 3));
            xa = q_a.pop_front();
            xb = q_b.pop_front();
            tests++;
            if (obs_a !== xa || obs_b !== xb) begin
                fails++;
                $display("FAIL ops[%0d] got a=%h b=%h exp a=%h b=%h", i, obs_a, obs_b, xa, xb);
            end
        end
    endtask

    task automatic test_idle_and_clr();
        string s = "19+7";
        logic       v [4];
        logic [12:0] e [4];
        logic [12:0] x;
        v = '{1'b1, 1'b0, 1'b1, 1'b0};
        e = '{pk(1,0,0,0,1), pk(1,0,0,0,1), pk(0,0,0,0,0), pk(0,0,0,0,0)};
        restart();
        for (int i = 0; i < s.len(); i++) begin
            q_a.push_back(e[i]);
            step(s[i], v[i], 1'b0);
            x = q_a.pop_front();
            tests++;
            if (obs_a !== x) begin
                fails++;
                $display("FAIL idle[%0d] got=%h exp=%h", i, obs_a, x);
            end
        end
        step(8'h35, 1'b1, 1'b1);
        tests++;
        if (obs_a !== pk(1,0,0,0,1)) begin
            fails++;
            $display("FAIL pre_clr got=%h exp=%h", obs_a, pk(1,0,0,0,1));
        end
        #2 clr = 1'b1;
        #1;
        tests++;
        if (obs_a !== 13'd0 || obs_b !== 13'd0) begin
            fails++;
            $display("FAIL async_clr got a=%h b=%h exp=0", obs_a, obs_b);
        end
        #2 clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_digovf();
        test_parens();
        test_depth_limit();
        test_leading_zero();
        test_ops_and_start();
        test_idle_and_clr();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/expr_stream_checker.md
Name: expr_stream_checker

Overview:
- Streaming ASCII arithmetic-expression validator, one character per accepted cycle.
- Generalises the single-digit "digit op digit" recogniser with:
  - multi-digit operands, bounded by a parameter
  - parenthesis nesting up to a parameterised depth
  - selectable operator set and a leading-zero rule
  - a sticky, classified error code
- Sits behind the UART/keyboard character front end and flags whether the stream received so far is a complete, well-formed expression.

Parameters:
- MAX_DIGITS, 4, max digits per operand (1..15).
- MAX_DEPTH, 7, max parenthesis nesting depth (1..15).
- OPS_EXT, 0, 0: operators '+' '*' only; 1: '+' '-' '*' '/'.
- ALLOW_LZ, 1, 1: leading zeros allowed; 0: a multi-digit operand starting with '0' is an error.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-high reset.
- start  in  1  synchronous restart of the checker.
- in  in  8  ASCII character.
- in_valid  in  1  character on in is consumed this cycle.
- out  out  1  stream so far is a complete valid expression.
- err  out  1  sticky error flag.
- err_code  out  3  first error cause.
- depth  out  4  current open-paren count.
- digit_cnt  out  4  digits in the current operand.

Behaviour:
- Clock and reset: one clock, clk. clr is asynchronous, active-high.
- Reset values:
  - state = OPND (expecting operand)
  - depth = 0, digit_cnt = 0, err_code = 0
  - out = 0, err = 0
- Character classes (combinational): DIGIT is "0".."9". OP is '+' or '*', plus '-' and '/' when OPS_EXT=1. LPAR is '('. RPAR is ')'. OTHER is everything else.
- Cycle handling:
  - Registers update only on cycles with in_valid=1 or start=1.
  - in_valid=0 holds all state.
- States and transitions (any transition not listed goes to ERR with code BADCHAR):
  - OPND:
    - DIGIT -> NUM, digit_cnt=1.
    - LPAR with depth<MAX_DEPTH -> OPND, depth+1.
    - LPAR with depth==MAX_DEPTH -> ERR, DEPTHOVF.
  - NUM:
    - DIGIT with digit_cnt<MAX_DIGITS -> NUM, digit_cnt+1.
    - DIGIT with digit_cnt==MAX_DIGITS -> ERR, DIGOVF.
    - DIGIT when ALLOW_LZ=0, digit_cnt==1 and the previous digit was '0' -> ERR, LEADZ. A one-bit lead_zero register holds "first digit was '0'".
    - OP -> OPND, digit_cnt=0.
    - RPAR with depth>0 -> CLOSE, depth-1, digit_cnt=0.
    - RPAR with depth==0 -> ERR, UNBAL.
  - CLOSE:
    - OP -> OPND.
    - RPAR follows the same depth rule as in NUM.
  - ERR: absorbing; only clr or start leave it.
- Error code priority when several causes coincide: DEPTHOVF and UNBAL are judged before BADCHAR. err_code latches on entry to ERR and is then frozen.
- Error code values: 0 NONE, 1 BADCHAR, 2 DIGOVF, 3 DEPTHOVF, 4 UNBAL, 5 LEADZ.
- Outputs:
  - out = (state==NUM or state==CLOSE) and depth==0, decoded from registers, so it is valid the cycle after the accepting character.
  - err = (state==ERR).
  - depth and digit_cnt are the register values.
- start:
  - Returns all registers to their reset values in the same edge.
  - If in_valid=1 on the same cycle, that character is evaluated from the OPND/depth 0 state, i.e. it becomes the first character of the new expression.
- Depth and digit_cnt never wrap; their limits are enforced by DEPTHOVF/DIGOVF.
- clr mid-stream: everything returns to reset values immediately and out drops asynchronously.

Decomposition:
- Shared package/include file holds:
  - state encodings OPND, NUM, CLOSE, ERR (2 bits)
  - error codes (3 bits)
  - ASCII constants for '0', '9', '+', '-', '*', '/', '(', ')'
- One natural sub-module, expr_char_class: purely combinational, parameter OPS_EXT, input in[7:0]; outputs is_digit, is_op, is_lpar, is_rpar, is_zero.
- Top module holds the FSM, counters, lead_zero flag and error latch.

Test Plan:
- Defaults, stream "12+(3*45)" with in_valid=1 each cycle -> out=1 after the final ')'; depth goes 0,0,0,1,1,1,1,1,0; err=0 throughout.
- MAX_DIGITS=4, stream "12345" -> err=1 and err_code=2 after the 5th char; out=1 after chars 1-4, then 0.
- Stream "((1)" -> out=0 with depth=1 at end. Follow-up ")" -> out=1, depth=0. A further ")" -> err_code=4.
- ALLOW_LZ=0, stream "07" -> err_code=5. Same stream with ALLOW_LZ=1 -> out=1, digit_cnt=2.
- OPS_EXT=0, stream "3-4" -> err_code=1 after '-'. Then start=1 with in_valid=1 and in="5" on the same cycle -> err=0, out=1, digit_cnt=1.
- Stream "1+" with in_valid toggled 0/1 between characters -> state holds on idle cycles, out=0 at end. Assert clr asynchronously mid-cycle -> all outputs 0 before the next clk edge.
